// File: rtl/dbg_pkg.sv
// Shared definitions for the debug reader: FSM states, default key and
// lockout threshold, and frame-length constants.
// Optional feature macro: DBG_READER_PARITY_EN (adds a trailing even-parity bit).
package dbg_pkg;

    localparam logic [31:0] KEY_DEFAULT      = 32'hA5C3_0F1E;
    localparam int          MAX_FAIL_DEFAULT = 3;
    localparam int          DATA_W           = 32;

`ifdef DBG_READER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR} state_e;
`else
    localparam int FRAME_LEN = DATA_W;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_e;
`endif

endpackage

// File: rtl/dbg_shift_tx.sv
// Serializer for the debug reader: captures a word, shifts it out LSB first,
// tracks the bit position and flags the last data bit / last frame bit.
// Optional feature macro: DBG_READER_PARITY_EN (parity bit after bit 31).
module dbg_shift_tx
    import dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              bit_o,
    output logic              last_data_o,
    output logic              last_frame_o
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;

    // Shift register and bit counter; clear wins so abort/completion leave zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
            cnt_q   <= '0;
        end else if (advance_i) begin
            shreg_q <= shreg_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign last_data_o  = (cnt_q == CNT_W'(DATA_W - 1));
    assign last_frame_o = (cnt_q == CNT_W'(FRAME_LEN - 1));

`ifdef DBG_READER_PARITY_EN
    logic par_q;

    // Even parity of the captured word, held for the trailing parity bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          par_q <= 1'b0;
        else if (clear_i) par_q <= 1'b0;
        else if (load_i)  par_q <= ^data_i;
    end

    assign bit_o = (cnt_q == CNT_W'(DATA_W)) ? par_q : shreg_q[0];
`else
    assign bit_o = shreg_q[0];
`endif

endmodule

// File: rtl/debug_reader.sv
// Key-protected debug readout: a key unlocks access, repeated bad keys lock
// the block out until reset, and an unlocked request streams one 32-bit
// source word out serially, LSB first.
// Optional feature macro: DBG_READER_PARITY_EN (33-bit frame with parity).
module debug_reader
    import dbg_pkg::*;
#(
    parameter logic [31:0] KEY      = KEY_DEFAULT,
    parameter int          MAX_FAIL = MAX_FAIL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [31:0] key_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_sel,
    input  logic [31:0] src_debug,
    input  logic [31:0] src_data,
    output logic        tx_valid,
    output logic        tx_bit,
    output logic        tx_last,
    output logic        unlocked,
    output logic        lockout,
    output logic        req_err
);

    localparam int                FAIL_W   = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_SAT = FAIL_W'(MAX_FAIL);

    state_e            state_q, state_d;
    logic              unlocked_q, unlocked_d;
    logic              lockout_q, lockout_d;
    logic              req_err_q, req_err_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic              ld, adv, clr;
    logic              sh_bit, last_data, last_frame;
    logic              busy;

    // Lock control: good key unlocks and clears failures, bad keys count up
    // (saturating) and lock out permanently at the threshold.
    always_comb begin
        unlocked_d = unlocked_q;
        lockout_d  = lockout_q;
        fail_d     = fail_q;
        if (key_valid && !lockout_q) begin
            if (key_in == KEY) begin
                unlocked_d = 1'b1;
                fail_d     = '0;
            end else begin
                unlocked_d = 1'b0;
                if (fail_q != FAIL_SAT) fail_d = fail_q + 1'b1;
                if (fail_d == FAIL_SAT) lockout_d = 1'b1;
            end
        end
    end

    // Request FSM: requests see the lock state registered before any key in
    // the same cycle; a frame aborts as soon as the lock is about to drop.
    always_comb begin
        state_d   = state_q;
        ld        = 1'b0;
        adv       = 1'b0;
        clr       = 1'b0;
        req_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (unlocked_q) begin
                        ld      = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        req_err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (!unlocked_d) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
`ifdef DBG_READER_PARITY_EN
                end else if (last_data) begin
                    adv     = 1'b1;
                    state_d = ST_PAR;
`else
                end else if (last_data) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
`endif
                end else begin
                    adv = 1'b1;
                end
            end
`ifdef DBG_READER_PARITY_EN
            ST_PAR: begin
                clr     = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State, lock and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
            fail_q     <= '0;
            req_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            unlocked_q <= unlocked_d;
            lockout_q  <= lockout_d;
            fail_q     <= fail_d;
            req_err_q  <= req_err_d;
        end
    end

    dbg_shift_tx u_shift (
        .clk          (clk),
        .rst          (rst),
        .load_i       (ld),
        .advance_i    (adv),
        .clear_i      (clr),
        .data_i       (req_sel ? src_data : src_debug),
        .bit_o        (sh_bit),
        .last_data_o  (last_data),
        .last_frame_o (last_frame)
    );

    assign busy      = (state_q != ST_IDLE);
    assign req_ready = !busy;
    assign tx_valid  = busy;
    assign tx_bit    = busy & sh_bit;
    assign tx_last   = busy & last_frame;
    assign unlocked  = unlocked_q;
    assign lockout   = lockout_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_debug_reader.sv
// Scoreboard bench for debug_reader: stimulus pushes expected serial bits,
// req_err pulses and flag checks; a negedge monitor pops and compares.
module tb_debug_reader;

    localparam logic [31:0] K   = 32'hA5C3_0F1E;
    localparam logic [31:0] BAD = 32'h1234_5678;
`ifdef DBG_READER_PARITY_EN
    localparam bit PAR  = 1'b1;
    localparam int FLEN = 33;
`else
    localparam bit PAR  = 1'b0;
    localparam int FLEN = 32;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [31:0] key_in;
    logic        req_valid;
    logic        req_ready;
    logic        req_sel;
    logic [31:0] src_debug;
    logic [31:0] src_data;
    logic        tx_valid;
    logic        tx_bit;
    logic        tx_last;
    logic        unlocked;
    logic        lockout;
    logic        req_err;

    int n_run  = 0;
    int n_fail = 0;

    logic [1:0]  txq[$];   // {last, bit}
    int          errq[$];
    string       cnm[$];
    logic [31:0] cact[$];
    logic [31:0] cexp[$];

    debug_reader dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_in    (key_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .src_debug (src_debug),
        .src_data  (src_data),
        .tx_valid  (tx_valid),
        .tx_bit    (tx_bit),
        .tx_last   (tx_last),
        .unlocked  (unlocked),
        .lockout   (lockout),
        .req_err   (req_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        cnm.push_back(nm);
        cact.push_back(a);
        cexp.push_back(e);
    endtask

    task automatic expect_bits(input logic [31:0] w, input int nbits, input bit full);
        for (int i = 0; i < nbits; i++)
            txq.push_back({(full && !PAR && i == 31), w[i]});
        if (full && PAR) txq.push_back({1'b1, ^w});
    endtask

    task automatic send_key(input logic [31:0] k);
        key_valid = 1'b1;
        key_in    = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_in    = '0;
    endtask

    task automatic send_req(input logic sel);
        req_valid = 1'b1;
        req_sel   = sel;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Monitor: the only process that compares and steps the counters.
    always @(negedge clk) begin
        logic [1:0] e;
        while (cnm.size() > 0) begin
            n_run++;
            if (cact[0] !== cexp[0]) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", cnm[0], cact[0], cexp[0]);
            end
            void'(cnm.pop_front());
            void'(cact.pop_front());
            void'(cexp.pop_front());
        end
        if (!rst) begin
            if (tx_valid) begin
                n_run++;
                if (txq.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_extra: got bit=%b last=%b expected no tx_valid", tx_bit, tx_last);
                end else begin
                    e = txq.pop_front();
                    if ({tx_last, tx_bit} !== e) begin
                        n_fail++;
                        $display("FAIL tx_bit: got last/bit=%b%b expected %b", tx_last, tx_bit, e);
                    end
                end
            end else begin
                n_run++;
                if ({tx_bit, tx_last} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL tx_idle: got bit=%b last=%b expected 00", tx_bit, tx_last);
                end
            end
            if (req_err) begin
                n_run++;
                if (errq.size() == 0 || tx_valid) begin
                    n_fail++;
                    $display("FAIL req_err: got unexpected pulse (tx_valid=%b) expected none", tx_valid);
                end else begin
                    void'(errq.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_in = '0; req_valid = 1'b0; req_sel = 1'b0;
        src_debug = '0; src_data = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_outs", {27'd0, tx_valid, tx_bit, tx_last, req_err, unlocked}, 32'd0);
        chk("rst_lockout", {31'd0, lockout}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Request with no key -> single req_err pulse, no frame
        errq.push_back(1);
        send_req(1'b0);
        repeat (3) @(posedge clk); #1;
        chk("err_idle_ready", {31'd0, req_ready}, 32'd1);

        // Key and request in the same cycle: request judged on old (locked) state
        errq.push_back(1);
        key_valid = 1'b1; key_in = K; req_valid = 1'b1; req_sel = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b0; key_in = '0; req_valid = 1'b0;
        chk("same_cycle_unlock", {31'd0, unlocked}, 32'd1);
        repeat (2) @(posedge clk); #1;

        // Debug word 0x8000_0001, source changed after capture
        src_debug = 32'h8000_0001; src_data = 32'hDEAD_BEEF;
        expect_bits(32'h8000_0001, 32, 1'b1);
        send_req(1'b0);
        src_debug = 32'hFFFF_FFFF;
        repeat (FLEN) @(posedge clk); #1;
        chk("frame1_ready", {31'd0, req_ready}, 32'd1);
        chk("frame1_txv", {31'd0, tx_valid}, 32'd0);

        // Data word 0x7 (parity 1 when enabled)
        src_data = 32'h0000_0007;
        expect_bits(32'h0000_0007, 32, 1'b1);
        send_req(1'b1);
        src_data = '0;
        repeat (FLEN) @(posedge clk); #1;
        chk("frame2_ready", {31'd0, req_ready}, 32'd1);

        // Abort: wrong key while bit 10 is on the wire
        src_debug = 32'hFFFF_FFFF;
        expect_bits(32'hFFFF_FFFF, 11, 1'b0);
        send_req(1'b0);
        repeat (10) @(posedge clk); #1;
        send_key(BAD);
        chk("abort_txv", {31'd0, tx_valid}, 32'd0);
        chk("abort_unlocked", {31'd0, unlocked}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(posedge clk); #1;

        // Lockout: good key clears count, then three bad keys
        send_key(K);
        chk("relock_unlocked", {31'd0, unlocked}, 32'd1);
        send_key(BAD);
        chk("bad1_unlocked", {31'd0, unlocked}, 32'd0);
        send_key(BAD);
        chk("bad2_lockout", {31'd0, lockout}, 32'd0);
        send_key(BAD);
        chk("bad3_lockout", {31'd0, lockout}, 32'd1);
        send_key(K);
        chk("locked_key_lockout", {31'd0, lockout}, 32'd1);
        chk("locked_key_unlocked", {31'd0, unlocked}, 32'd0);
        errq.push_back(1);
        send_req(1'b0);
        repeat (2) @(posedge clk); #1;

        // Reset clears lockout
        rst = 1'b1; #1;
        chk("rst_clears_lockout", {31'd0, lockout}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-frame: five bits out, then truncation
        send_key(K);
        src_debug = 32'h0000_00A5;
        expect_bits(32'h0000_00A5, 5, 1'b0);
        send_req(1'b0);
        repeat (5) @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("midrst_outs", {27'd0, tx_valid, tx_bit, tx_last, req_err, unlocked}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk); #1;
        errq.push_back(1);
        send_req(1'b0);
        repeat (3) @(posedge clk); #1;

        chk("txq_drained", 32'(txq.size()), 32'd0);
        chk("errq_drained", 32'(errq.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_reader.md
DEBUG_READER -- requirements
Module: debug_reader

Interface
REQ-001 SHALL have parameter KEY, default 32'hA5C3_0F1E; the unlock key value.
REQ-002 SHALL have parameter MAX_FAIL, default 3; the number of bad key attempts that triggers permanent lockout.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port key_valid  input  1  key-attempt strobe.
REQ-006 SHALL have port key_in  input  32  key value presented with key_valid.
REQ-007 SHALL have port req_valid  input  1  read request.
REQ-008 SHALL have port req_ready  output  1  request accepted when high together with req_valid.
REQ-009 SHALL have port req_sel  input  1  source select: 0 selects src_debug, 1 selects src_data.
REQ-010 SHALL have port src_debug  input  32  debug word from the monitored block.
REQ-011 SHALL have port src_data  input  32  data word from the monitored block.
REQ-012 SHALL have port tx_valid  output  1  serial bit valid.
REQ-013 SHALL have port tx_bit  output  1  serial data, LSB first.
REQ-014 SHALL have port tx_last  output  1  marks the final serial bit of a frame.
REQ-015 SHALL have port unlocked  output  1  access granted.
REQ-016 SHALL have port lockout  output  1  sticky lockout flag.
REQ-017 SHALL have port req_err  output  1  one-cycle pulse when a request is denied.

Function
REQ-018 SHALL implement an FSM with states IDLE, SHIFT and (when parity is enabled) PAR; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL set unlocked=1 on the cycle after a key_valid whose key_in==KEY, provided lockout=0, and SHALL clear the fail counter at the same time.
REQ-020 SHALL increment the fail counter on each key_valid with key_in!=KEY; while unlocked, such a key SHALL also clear unlocked.
REQ-021 SHALL set lockout=1 and unlocked=0 when the fail counter reaches MAX_FAIL; lockout SHALL stay set until rst, and SHALL cause all subsequent key_valid to be ignored.
REQ-022 SHALL respond to a handshake in IDLE with unlocked=0 by pulsing req_err for exactly one cycle on the following cycle, with no tx_valid and the FSM remaining in IDLE.
REQ-023 SHALL respond to a handshake in IDLE with unlocked=1 by capturing the selected source word at that clock edge and entering SHIFT.
REQ-024 SHALL, in SHIFT, drive tx_valid=1 for 32 consecutive cycles starting on the cycle after the handshake, with tx_bit carrying bits 0..31 in order.
REQ-025 SHALL assert tx_last with bit 31, or with the parity bit when parity is enabled, and SHALL return to IDLE on the next cycle.
REQ-026 SHALL evaluate a request and a key_valid arriving in the same cycle against the registered lock state from before that key update.
REQ-027 SHALL abort a frame in progress when unlocked clears during SHIFT or PAR: tx_valid=0 from the next cycle, no tx_last, return to IDLE.
REQ-028 SHALL zero the shift register on abort and on frame completion, and SHALL drive tx_bit=0 whenever tx_valid=0.
REQ-029 SHALL size the fail counter to hold MAX_FAIL and SHALL saturate it there (no wrap-around).

Reset
REQ-030 SHALL, on rst assertion, immediately force the FSM to IDLE, unlocked=0, lockout=0, the fail counter to 0 and the shift register to 0.
REQ-031 SHALL, while rst is asserted, drive req_ready=1 and tx_valid, tx_bit, tx_last, req_err=0.
REQ-032 SHALL, on rst during a frame, truncate the frame with no further bits after release.

Configuration
REQ-033 SHALL, when macro DBG_READER_PARITY_EN is defined, append one PAR cycle after bit 31 that carries the even parity (XOR) of the 32 captured bits, making the frame 33 bits long with tx_last on the parity bit.
REQ-034 SHALL, without DBG_READER_PARITY_EN, have no PAR state and a 32-bit frame.

Structure
REQ-035 SHALL place the FSM state enum, the KEY default, the MAX_FAIL default and the frame-length constants in shared package dbg_pkg.
REQ-036 SHALL implement the serializer (load, shift, bit count, last/parity generation) as sub-module dbg_shift_tx; lock control and the FSM SHALL remain in debug_reader.

Verification
REQ-037 SHALL cover: req_valid with no key after reset -> req_err pulse on the next cycle, tx_valid stays 0.
REQ-038 SHALL cover: key 32'hA5C3_0F1E, then a request with req_sel=0 and src_debug=32'h8000_0001 -> 32 tx_valid cycles, bits 1,0,...,0,1, tx_last on the 32nd cycle, req_ready high on the following cycle.
REQ-039 SHALL cover: three wrong keys, then the correct key -> lockout=1, unlocked=0, and a request gives req_err.
REQ-040 SHALL cover: unlock, start a frame, then a wrong key at bit 10 -> tx_valid low from bit 11, no tx_last, unlocked=0.
REQ-041 SHALL cover: with DBG_READER_PARITY_EN, sending src_data=32'h0000_0007 -> 33 bits, parity bit=1 with tx_last.
REQ-042 SHALL cover: rst asserted mid-frame -> all outputs at reset values in the same cycle, and lockout cleared.
